// File: rtl/mod_ramp_gen.sv
// Square-wave bias modulation, half-period trigger and serrodyne ramp summed into a registered DAC code.
// Outputs registered one clock after their inputs, no backpressure; `define RAMP_SAT_EN for a saturating ramp plus o_ramp_sat.
module mod_ramp_gen #(
  parameter int DAC_BIT = 16,
  parameter int CNT_BIT = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [CNT_BIT-1:0] i_freq_cnt,
  input  logic [DAC_BIT-1:0] i_mod_h,
  input  logic [DAC_BIT-1:0] i_mod_l,
  input  logic [31:0]        i_step,
  input  logic               i_step_sync,
  input  logic [4:0]         i_gain_sel,
  output logic               o_polarity,
  output logic               o_trig,
  output logic [DAC_BIT-1:0] o_dac,
  output logic [31:0]        o_ramp,
  output logic               o_ramp_wrap,
`ifdef RAMP_SAT_EN
  output logic               o_ramp_sat,
`endif
  output logic [1:0]         o_cstate
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MOD_L = 2'd1;
  localparam logic [1:0] MOD_H = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic               pol_q, pol_d;
  logic               trig_q, trig_d;
  logic [DAC_BIT-1:0] dac_q, dac_d;
  logic [31:0]        ramp_q, ramp_d;
  logic               wrap_q, wrap_d;
`ifdef RAMP_SAT_EN
  logic               sat_q, sat_d;
`endif

  logic [CNT_BIT-1:0] reload_cnt;
  logic signed [31:0] step_sh;
  logic [31:0]        ramp_sum;
  logic               ramp_ovf;
  logic [DAC_BIT-1:0] mod_sel;

  // Counter runs N-1 down to 0, so each half lasts exactly max(i_freq_cnt,2) cycles.
  assign reload_cnt = (i_freq_cnt < CNT_BIT'(2)) ? CNT_BIT'(1) : i_freq_cnt - CNT_BIT'(1);
  assign step_sh    = $signed(i_step) >>> i_gain_sel;
  assign ramp_sum   = ramp_q + step_sh;
  assign ramp_ovf   = (ramp_q[31] == step_sh[31]) && (ramp_sum[31] != ramp_q[31]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    wrap_d  = 1'b0;
    ramp_d  = ramp_q;
    if (!i_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ramp_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = MOD_L;
      cnt_d   = reload_cnt;
      trig_d  = 1'b1;
      ramp_d  = '0;
    end else begin
      if (cnt_q == '0) begin
        state_d = (state_q == MOD_L) ? MOD_H : MOD_L;
        cnt_d   = reload_cnt;
        trig_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_BIT'(1);
      end
      if (i_step_sync) begin
`ifdef RAMP_SAT_EN
        ramp_d = ramp_ovf ? (ramp_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : ramp_sum;
`else
        ramp_d = ramp_sum;
        wrap_d = ramp_ovf;
`endif
      end
    end
    pol_d   = (state_d == MOD_H);
    mod_sel = pol_d ? i_mod_h : i_mod_l;
    // DAC sees the ramp and polarity being registered this cycle, not the stale ones.
    dac_d   = (state_d == IDLE) ? '0 : ramp_d[31 -: DAC_BIT] + mod_sel;
`ifdef RAMP_SAT_EN
    sat_d   = (ramp_d == 32'h7FFF_FFFF) || (ramp_d == 32'h8000_0000);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pol_q   <= 1'b0;
      trig_q  <= 1'b0;
      dac_q   <= '0;
      ramp_q  <= '0;
      wrap_q  <= 1'b0;
`ifdef RAMP_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      trig_q  <= trig_d;
      dac_q   <= dac_d;
      ramp_q  <= ramp_d;
      wrap_q  <= wrap_d;
`ifdef RAMP_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign o_polarity  = pol_q;
  assign o_trig      = trig_q;
  assign o_dac       = dac_q;
  assign o_ramp      = ramp_q;
  assign o_ramp_wrap = wrap_q;
  assign o_cstate    = state_q;
`ifdef RAMP_SAT_EN
  assign o_ramp_sat  = sat_q;
`endif

endmodule

// File: tb/tb_mod_ramp_gen.sv
// Bench for mod_ramp_gen: cycle-level scoreboard plus directed scenario checks.
module tb_mod_ramp_gen;

  logic        clk = 1'b0;
  logic        rst, en, step_sync;
  logic [31:0] freq, step;
  logic [15:0] mod_h, mod_l;
  logic [4:0]  gain;
  logic        o_polarity, o_trig, o_ramp_wrap, dut_sat;
  logic [15:0] o_dac;
  logic [31:0] o_ramp;
  logic [1:0]  o_cstate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_ramp_gen #(.DAC_BIT(16), .CNT_BIT(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_freq_cnt(freq),
    .i_mod_h(mod_h), .i_mod_l(mod_l), .i_step(step), .i_step_sync(step_sync),
    .i_gain_sel(gain), .o_polarity(o_polarity), .o_trig(o_trig), .o_dac(o_dac),
    .o_ramp(o_ramp), .o_ramp_wrap(o_ramp_wrap),
`ifdef RAMP_SAT_EN
    .o_ramp_sat(dut_sat),
`endif
    .o_cstate(o_cstate)
  );
`ifndef RAMP_SAT_EN
  assign dut_sat = 1'b0;
`endif

  typedef struct packed {
    logic        pol;
    logic        trig;
    logic [15:0] dac;
    logic [31:0] ramp;
    logic        wrap;
    logic        sat;
    logic [1:0]  cstate;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Behavioural model: counts cycles up from the start of each half.
  logic        m_run, m_pol;
  logic [31:0] m_ramp;
  int          m_pos, m_len;

  task automatic cycle();
    exp_t e;
    logic signed [31:0] sh;
    logic [31:0] sum;
    int len_in;
    len_in = (freq < 2) ? 2 : int'(freq);
    e.trig = 1'b0;
    e.wrap = 1'b0;
    if (rst || !en) begin
      m_run = 0; m_pol = 0; m_ramp = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pol = 0; m_pos = 0; m_len = len_in; m_ramp = 0; e.trig = 1'b1;
    end else begin
      m_pos++;
      if (m_pos == m_len) begin
        m_pos = 0; m_pol = ~m_pol; m_len = len_in; e.trig = 1'b1;
      end
      if (step_sync) begin
        sh  = $signed(step) >>> gain;
        sum = m_ramp + sh;
        if ((m_ramp[31] == sh[31]) && (sum[31] != m_ramp[31])) begin
`ifdef RAMP_SAT_EN
          sum = m_ramp[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
          e.wrap = 1'b1;
`endif
        end
        m_ramp = sum;
      end
    end
    e.pol    = m_pol;
    e.ramp   = m_ramp;
    e.cstate = m_run ? (m_pol ? 2'd2 : 2'd1) : 2'd0;
    e.dac    = m_run ? 16'(m_ramp[31:16] + (m_pol ? mod_h : mod_l)) : 16'h0;
`ifdef RAMP_SAT_EN
    e.sat    = (m_ramp == 32'h7FFF_FFFF) || (m_ramp == 32'h8000_0000);
`else
    e.sat    = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({o_polarity, o_trig, o_ramp_wrap, dut_sat} !== {mon_e.pol, mon_e.trig, mon_e.wrap, mon_e.sat}) begin
        errors++;
        $display("FAIL sb_flags t=%0t pol/trig/wrap/sat got %b%b%b%b exp %b%b%b%b", $time,
                 o_polarity, o_trig, o_ramp_wrap, dut_sat, mon_e.pol, mon_e.trig, mon_e.wrap, mon_e.sat);
      end
      checks++;
      if (o_ramp !== mon_e.ramp) begin
        errors++; $display("FAIL sb_ramp t=%0t got %h exp %h", $time, o_ramp, mon_e.ramp);
      end
      checks++;
      if (o_dac !== mon_e.dac) begin
        errors++; $display("FAIL sb_dac t=%0t got %h exp %h", $time, o_dac, mon_e.dac);
      end
      checks++;
      if (o_cstate !== mon_e.cstate) begin
        errors++; $display("FAIL sb_cstate t=%0t got %0d exp %0d", $time, o_cstate, mon_e.cstate);
      end
    end
  end

  task automatic restart(input logic [31:0] f);
    rst = 1; en = 0; step_sync = 0;
    cycle();
    rst = 0; en = 1; freq = f;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1; en = 0; freq = 10; mod_h = 0; mod_l = 0; step = 0; step_sync = 0; gain = 0;
    cycle(); cycle();
    checks++;
    if ({o_polarity, o_trig, o_ramp_wrap, dut_sat, o_cstate} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000", {o_polarity, o_trig, o_ramp_wrap, dut_sat, o_cstate});
    end
    checks++;
    if ({o_dac, o_ramp} !== 48'h0) begin
      errors++; $display("FAIL reset_data dac %h ramp %h exp 0", o_dac, o_ramp);
    end
    rst = 0;
    cycle();
    checks++;
    if (o_cstate !== 2'd0) begin
      errors++; $display("FAIL idle_hold cstate got %0d exp 0", o_cstate);
    end
  endtask

  task automatic test_period();
    int last, ntrig;
    restart(10);
    checks++;
    if ({o_trig, o_cstate, o_polarity} !== 4'b1010) begin
      errors++; $display("FAIL first_trig trig/cstate/pol got %b exp 1010", {o_trig, o_cstate, o_polarity});
    end
    last = 0; ntrig = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (o_trig) begin
        ntrig++;
        checks++;
        if (i - last != 10) begin
          errors++; $display("FAIL period_len got %0d exp 10", i - last);
        end
        checks++;
        if (o_polarity !== 1'(ntrig % 2)) begin
          errors++; $display("FAIL period_pol got %b exp %b", o_polarity, 1'(ntrig % 2));
        end
        last = i;
      end
    end
    checks++;
    if (ntrig != 4) begin
      errors++; $display("FAIL period_count got %0d exp 4", ntrig);
    end
  endtask

  task automatic test_min_period();
    int t1, t2;
    for (int f = 0; f < 2; f++) begin
      restart(32'(f));
      for (int i = 1; i <= 6; i++) begin
        cycle();
        checks++;
        if (o_trig !== (i % 2 == 0)) begin
          errors++; $display("FAIL min_period f=%0d i=%0d trig got %b exp %b", f, i, o_trig, (i % 2 == 0));
        end
      end
    end
    restart(10);
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) freq = 20;
      cycle();
      if (o_trig && t1 < 0) t1 = i;
      else if (o_trig && t2 < 0) t2 = i;
    end
    checks++;
    if (t1 != 10 || t2 != 30) begin
      errors++; $display("FAIL freq_change trig at %0d,%0d exp 10,30", t1, t2);
    end
  endtask

  task automatic test_ramp_dac();
    bit seen;
    mod_h = 16'd1000; mod_l = 16'hFC18;
    restart(10);
    step = 32'h0001_0000; gain = 0; step_sync = 1;
    cycle(); cycle(); cycle();
    step_sync = 0;
    checks++;
    if (o_ramp !== 32'h0003_0000) begin
      errors++; $display("FAIL ramp_acc got %h exp 00030000", o_ramp);
    end
    checks++;
    if (o_dac !== 16'hFC1B || o_polarity !== 1'b0) begin
      errors++; $display("FAIL dac_low got %h pol %b exp fc1b pol 0", o_dac, o_polarity);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = o_polarity;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL dac_high timeout waiting for polarity 1");
    end else if (o_dac !== 16'd1003) begin
      errors++; $display("FAIL dac_high got %h exp 03eb", o_dac);
    end
  endtask

  task automatic test_wrap();
    restart(50);
    gain = 0; step = 32'h7FFF_0000; step_sync = 1;
    cycle();
    checks++;
    if (o_ramp !== 32'h7FFF_0000) begin
      errors++; $display("FAIL wrap_pre got %h exp 7fff0000", o_ramp);
    end
    step = 32'h0002_0000;
    cycle();
    step_sync = 0;
`ifdef RAMP_SAT_EN
    checks++;
    if (o_ramp !== 32'h7FFF_FFFF || dut_sat !== 1'b1 || o_ramp_wrap !== 1'b0) begin
      errors++; $display("FAIL sat_hit ramp %h sat %b wrap %b exp 7fffffff 1 0", o_ramp, dut_sat, o_ramp_wrap);
    end
`else
    checks++;
    if (o_ramp !== 32'h8001_0000 || o_ramp_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_hit ramp %h wrap %b exp 80010000 1", o_ramp, o_ramp_wrap);
    end
`endif
    cycle();
    checks++;
    if (o_ramp_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse got %b exp 0", o_ramp_wrap);
    end
  endtask

  task automatic test_shift_boundary();
    mod_h = 16'd1000; mod_l = 16'hFC18;
    restart(4);
    step = 32'hFFFF_FF00; gain = 5'd4; step_sync = 1;
    cycle();
    step_sync = 0;
    checks++;
    if (o_ramp !== 32'hFFFF_FFF0 || o_dac !== 16'hFC17) begin
      errors++; $display("FAIL shift ramp %h dac %h exp fffffff0 fc17", o_ramp, o_dac);
    end
    cycle(); cycle();
    step_sync = 1;
    cycle();
    checks++;
    if ({o_trig, o_polarity} !== 2'b11 || o_ramp !== 32'hFFFF_FFE0 || o_dac !== 16'd999) begin
      errors++; $display("FAIL step_at_boundary trig %b pol %b ramp %h dac %h exp 1 1 ffffffe0 03e7",
                         o_trig, o_polarity, o_ramp, o_dac);
    end
    cycle();
    checks++;
    if (o_ramp !== 32'hFFFF_FFD0) begin
      errors++; $display("FAIL back_to_back_1 got %h exp ffffffd0", o_ramp);
    end
    cycle();
    step_sync = 0;
    checks++;
    if (o_ramp !== 32'hFFFF_FFC0) begin
      errors++; $display("FAIL back_to_back_2 got %h exp ffffffc0", o_ramp);
    end
  endtask

  task automatic test_disable();
    bit seen;
    restart(4);
    step = 32'h0010_0000; gain = 0; step_sync = 1;
    cycle();
    step_sync = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = o_polarity;
    end
    cycle();
    checks++;
    if (!seen || o_cstate !== 2'd2) begin
      errors++; $display("FAIL disable_setup cstate got %0d exp 2", o_cstate);
    end
    en = 0;
    cycle();
    checks++;
    if ({o_cstate, o_polarity, o_trig} !== 4'b0 || o_dac !== 16'h0 || o_ramp !== 32'h0) begin
      errors++; $display("FAIL disable cstate %0d pol %b trig %b dac %h ramp %h exp all 0",
                         o_cstate, o_polarity, o_trig, o_dac, o_ramp);
    end
    en = 1;
    cycle();
    checks++;
    if ({o_trig, o_cstate} !== 3'b101) begin
      errors++; $display("FAIL reenable trig/cstate got %b exp 101", {o_trig, o_cstate});
    end
  endtask

  task automatic test_reset_mid();
    restart(10);
    step = 32'h0123_0000; gain = 0; step_sync = 1;
    cycle(); cycle();
    step_sync = 0;
    rst = 1;
    cycle();
    checks++;
    if ({o_polarity, o_trig, o_ramp_wrap, dut_sat, o_cstate} !== 6'b0 || {o_dac, o_ramp} !== 48'h0) begin
      errors++; $display("FAIL reset_mid cstate %0d dac %h ramp %h exp all 0", o_cstate, o_dac, o_ramp);
    end
    rst = 0;
    cycle();
    checks++;
    if ({o_trig, o_cstate} !== 3'b101) begin
      errors++; $display("FAIL reset_recover trig/cstate got %b exp 101", {o_trig, o_cstate});
    end
  endtask

  initial begin
    m_run = 0; m_pol = 0; m_ramp = 0; m_pos = 0; m_len = 2;
    test_reset();
    test_period();
    test_min_period();
    test_ramp_dac();
    test_wrap();
    test_shift_boundary();
    test_disable();
    test_reset_mid();
    en = 0;
    cycle();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d entries exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_ramp_gen.md
Name: mod_ramp_gen

Overview:
- Modulation and ramp DAC driver for the PIG closed loop; the drive-side counterpart of the error-signal demodulator.
- Generates the square-wave bias modulation, the polarity level and the half-period trigger strobe that the demodulator consumes.
- Accepts the loop step value on each step strobe, accumulates it into a serrodyne ramp, and sums ramp and modulation into the registered DAC code.

Parameters:
- DAC_BIT, 16, DAC code width (two's complement).
- CNT_BIT, 32, width of the half-period counter and of i_freq_cnt.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  run enable; 0 forces IDLE.
- i_freq_cnt  in  CNT_BIT  half-period length in clocks; values below 2 are treated as 2.
- i_mod_h  in  DAC_BIT  signed modulation level while polarity=1.
- i_mod_l  in  DAC_BIT  signed modulation level while polarity=0.
- i_step  in  32  signed loop step.
- i_step_sync  in  1  one-cycle strobe; i_step is valid in this cycle.
- i_gain_sel  in  5  arithmetic right-shift applied to i_step (0..31).
- o_polarity  out  1  modulation level: 0=low half, 1=high half.
- o_trig  out  1  one-cycle pulse at the start of every half-period.
- o_dac  out  DAC_BIT  registered DAC code.
- o_ramp  out  32  ramp accumulator.
- o_ramp_wrap  out  1  one-cycle pulse on ramp signed overflow (2π reset event).
- o_cstate  out  2  state, for debug.

Behaviour:
Interface
- One clock, i_clk. Reset i_rst is synchronous and active-high.

Reset values
- While i_rst=1, at each clock edge all outputs and state registers go to 0: o_polarity, o_trig, o_dac, o_ramp, o_ramp_wrap, o_cstate=IDLE, counter.
- Reset mid-operation aborts with no partial update.

States: IDLE=0, MOD_L=1, MOD_H=2.
- IDLE:
  - o_polarity=0, o_trig=0, counter=0, ramp cleared to 0.
  - If i_en=1, go to MOD_L next cycle and pulse o_trig in that first MOD_L cycle.
  - On entry, counter loads max(i_freq_cnt,2)-1.
- MOD_L / MOD_H:
  - Counter decrements each cycle.
  - When counter=0: switch to the other MOD state, toggle o_polarity, pulse o_trig for one cycle, and reload the counter from the current i_freq_cnt.
  - i_freq_cnt is sampled only at a reload.
  - Each half-period is therefore exactly max(i_freq_cnt,2) cycles; o_trig period equals the half-period.
- Any state: i_en=0 → IDLE next cycle. o_trig is not asserted on that transition.
- o_polarity=1 exactly in MOD_H.

Ramp
- In MOD states, on i_step_sync=1: ramp <= ramp + (i_step >>> i_gain_sel). The shift is a sign-preserving arithmetic shift.
- Addition is 32-bit two's complement with natural wrap.
- o_ramp_wrap=1 in the cycle after an add whose operands have equal signs and whose result sign differs.
- i_step_sync in IDLE is ignored.

DAC
- o_dac <= ramp_next[31:32-DAC_BIT] + (polarity_next ? i_mod_h : i_mod_l), modulo 2^DAC_BIT (wraps, no saturation).
- ramp_next and polarity_next are the values being registered in the same cycle, so o_dac reflects them in the same cycle o_ramp/o_polarity change (both registered, one-clock latency from the stimulus edge).
- In IDLE, o_dac=0.

Simultaneous events
- i_step_sync together with a half-period boundary: both apply in the same cycle, and o_dac uses the new ramp and the new polarity.
- Two i_step_sync strobes in consecutive cycles: each is accumulated.

Optional Feature:
- Macro: RAMP_SAT_EN.
- Defined:
  - The ramp accumulator saturates at 0x7FFFFFFF / 0x80000000 instead of wrapping.
  - o_ramp_wrap stays 0.
  - An extra output o_ramp_sat (1 bit) is high while the ramp sits at either limit; it resets to 0.
- Undefined: natural wrap as above, and o_ramp_sat does not exist.

Test Plan:
1. Reset then i_en=1, i_freq_cnt=10 → o_trig pulses every 10 cycles; o_polarity reads 0,1,0… per half; the first trig is in the first MOD_L cycle.
2. i_freq_cnt=0 and i_freq_cnt=1 → half-period is 2 cycles. Change i_freq_cnt 10→20 mid-half → the current half stays 10 cycles and the next is 20.
3. DAC_BIT=16, i_mod_h=1000, i_mod_l=-1000, i_step=0x00010000, gain_sel=0, three step strobes → o_ramp=0x00030000, o_dac=3+1000 in high half and 3-1000 (0xFC1B) in low half.
4. ramp=0x7FFF0000, i_step=0x00020000 → o_ramp=0x80010000 and o_ramp_wrap pulses one cycle. With RAMP_SAT_EN: o_ramp=0x7FFFFFFF, o_ramp_sat=1, no wrap pulse.
5. i_step=-256, gain_sel=4 → ramp decreases by 16. The same step strobed together with a half-period boundary → the new polarity and the new ramp both appear in o_dac the same cycle.
6. Drop i_en mid-MOD_H → IDLE next cycle, o_polarity=0, o_dac=0, ramp=0, no o_trig. Assert i_rst mid-run → all outputs 0 at the next edge.
